// File: rtl/melody_seq_if.sv
// Note ROM bus between melody_seq (master) and a registered note ROM (slave).
// Entry layout on rom_data: {last, dur, div}.
interface melody_seq_if #(
    parameter int ADDR_W = 7,
    parameter int DUR_W  = 3,
    parameter int DIV_W  = 17
);
    logic [ADDR_W-1:0]      rom_addr;
    logic [DUR_W+DIV_W:0]   rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/melody_seq.sv
// Table-driven melody sequencer: walks a registered note ROM and drives a tone divider/enable.
// Optional macro MELODY_SEQ_GAP_EN silences the final tick of every note.
module melody_seq #(
    parameter int DIV_W    = 17,
    parameter int ADDR_W   = 7,
    parameter int DUR_W    = 3,
    parameter int TPU_LOG2 = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tempo,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    melody_seq_if.master     rom,
    output logic [DIV_W-1:0] div,
    output logic             enable,
    output logic             busy,
    output logic             done
);
    localparam int REM_W = DUR_W + TPU_LOG2 + 1;
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [REM_W-1:0]  remain_reg, remain_next;
    logic              last_reg, last_next;
    logic              pend_reg, pend_next;
    logic              enable_reg, enable_next;
    logic              done_reg, done_next;

    // [0] metastability flop, [1] synchronised tempo, [2] previous synchronised value
    logic [2:0]        tempo_pipe_reg;
    logic              tick_reg;

    logic              rom_last;
    logic [DUR_W-1:0]  rom_dur;
    logic [DIV_W-1:0]  rom_div;
    logic [REM_W-1:0]  note_len;
    logic              step;
    logic              gap_ok;

    assign {rom_last, rom_dur, rom_div} = rom.rom_data;
    assign note_len = ({{(TPU_LOG2 + 1){1'b0}}, rom_dur} + REM_ONE) << TPU_LOG2;
    assign step     = tick_reg | pend_reg;

`ifdef MELODY_SEQ_GAP_EN
    assign gap_ok = (remain_reg != REM_ONE);
`else
    assign gap_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            tempo_pipe_reg <= '0;
            tick_reg       <= 1'b0;
        end else begin
            tempo_pipe_reg <= {tempo_pipe_reg[1:0], tempo};
            tick_reg       <= tempo_pipe_reg[1] & ~tempo_pipe_reg[2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= '0;
            div_reg    <= '0;
            remain_reg <= '0;
            last_reg   <= 1'b0;
            pend_reg   <= 1'b0;
            enable_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            div_reg    <= div_next;
            remain_reg <= remain_next;
            last_reg   <= last_next;
            pend_reg   <= pend_next;
            enable_reg <= enable_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        div_next    = div_reg;
        remain_next = remain_reg;
        last_next   = last_reg;
        pend_next   = pend_reg;
        enable_next = enable_reg;
        done_next   = 1'b0;

        if (stop) begin
            state_next  = ST_IDLE;
            div_next    = '0;
            enable_next = 1'b0;
            pend_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    enable_next = 1'b0;
                    pend_next   = 1'b0;
                    if (start) begin
                        addr_next  = '0;
                        state_next = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    pend_next  = pend_reg | tick_reg;
                    state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    pend_next   = pend_reg | tick_reg;
                    div_next    = rom_div;
                    last_next   = rom_last;
                    remain_next = note_len;
                    state_next  = ST_PLAY;
                end
                ST_PLAY: begin
                    pend_next   = 1'b0;
                    enable_next = (div_reg != '0) && gap_ok;
                    if (step) begin
                        if (remain_reg == REM_ONE) begin
                            if (!last_reg) begin
                                addr_next  = addr_reg + 1'b1;
                                state_next = ST_FETCH;
                            end else if (loop) begin
                                addr_next  = '0;
                                state_next = ST_FETCH;
                            end else begin
                                state_next  = ST_IDLE;
                                div_next    = '0;
                                enable_next = 1'b0;
                                done_next   = 1'b1;
                            end
                        end else begin
                            remain_next = remain_reg - REM_ONE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign rom.rom_addr = addr_reg;
    assign div          = div_reg;
    assign enable       = enable_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign done         = done_reg;

endmodule

// File: tb/tb_melody_seq.sv
// Randomised and directed bench for melody_seq against a tick-level behavioural model.
module tb_melody_seq;
    localparam int DIV_W = 17;
    localparam int ADDR_W = 7;
    localparam int DUR_W = 3;
    localparam int TPU_LOG2 = 3;
    localparam int NENT = 1 << ADDR_W;
`ifdef MELODY_SEQ_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif
    localparam int M6 = 3189;
    localparam int M7 = 2841;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tempo = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic loop = 1'b0;
    logic [DIV_W-1:0] div;
    logic enable, busy, done;

    melody_seq_if #(.ADDR_W(ADDR_W), .DUR_W(DUR_W), .DIV_W(DIV_W)) bus ();

    melody_seq #(.DIV_W(DIV_W), .ADDR_W(ADDR_W), .DUR_W(DUR_W), .TPU_LOG2(TPU_LOG2)) dut (
        .clk(clk), .reset(reset), .tempo(tempo), .start(start), .stop(stop), .loop(loop),
        .rom(bus), .div(div), .enable(enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DUR_W+DIV_W:0] rom_mem [NENT];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DUR_W+DIV_W:0] ent(input bit l, input int d, input int v);
        return {l, DUR_W'(d), DIV_W'(v)};
    endfunction

    // tempo square wave: fixed or randomly jittered half period
    int tempo_half = 10;
    bit tempo_rand = 1'b0;
    initial begin
        forever begin
            int h;
            h = tempo_rand ? int'($urandom_range(12, 2)) : tempo_half;
            repeat (h) @(negedge clk);
            tempo = ~tempo;
        end
    end

    // ---------------- behavioural model ----------------
    logic [3:0] hist = '0;      // hist[k] = tempo sampled k+1 edges ago
    bit m_tick, m_active, m_done, m_en, m_pend, m_last;
    int m_addr, m_div, m_wait, m_left;

    task automatic model_step();
        bit tk, t, en_n;
        logic [DUR_W+DIV_W:0] e;
        tk = hist[2] & ~hist[3];
        m_tick = 1'b0;
        m_done = 1'b0;
        if (reset) begin
            hist = '0; m_active = 0; m_addr = 0; m_div = 0; m_en = 0;
            m_wait = 0; m_pend = 0; m_left = 0; m_last = 0;
            return;
        end
        hist = {hist[2:0], tempo};
        m_tick = tk;
        if (stop) begin
            m_active = 0; m_div = 0; m_en = 0; m_pend = 0; m_wait = 0;
        end else if (!m_active) begin
            m_en = 0; m_pend = 0;
            if (start) begin m_active = 1; m_addr = 0; m_wait = 2; end
        end else if (m_wait > 0) begin
            if (tk) m_pend = 1;
            m_wait--;
            if (m_wait == 0) begin
                e = rom_mem[m_addr];
                m_div  = int'(e[DIV_W-1:0]);
                m_left = (int'(e[DIV_W +: DUR_W]) + 1) << TPU_LOG2;
                m_last = e[DUR_W+DIV_W];
            end
        end else begin
            en_n = (m_div != 0) && !(GAP && m_left == 1);
            t = tk | m_pend;
            m_pend = 0;
            if (t) begin
                if (m_left == 1) begin
                    if (!m_last) begin m_addr = (m_addr + 1) % NENT; m_wait = 2; end
                    else if (loop) begin m_addr = 0; m_wait = 2; end
                    else begin m_active = 0; m_done = 1; m_div = 0; en_n = 0; end
                end else begin
                    m_left--;
                end
            end
            m_en = en_n;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process + scenario counters ----------------
    int cnt_m6, cnt_m7, cnt_rest, cnt_gap, cnt_done, en_rest;
    bit wrap1, wrap127;
    int p_addr = 0, p_div = 0;
    bit p_busy = 0, p_en = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("addr", bus.rom_addr, m_addr);
            chk("div", div, m_div);
            chk("enable", enable, m_en);
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            if (m_tick && p_busy) begin
                if (p_div == M6) cnt_m6++;
                if (p_div == M7) cnt_m7++;
                if (p_div == 0) cnt_rest++;
                if (p_div != 0 && !p_en) cnt_gap++;
            end
            if (busy && div == 0 && enable) en_rest++;
            if (done) cnt_done++;
            if (busy && p_addr == 1 && bus.rom_addr == 0) wrap1 = 1;
            if (busy && p_addr == NENT - 1 && bus.rom_addr == 0) wrap127 = 1;
            p_addr = int'(bus.rom_addr); p_div = int'(div); p_busy = busy; p_en = enable;
        end
    end

    task automatic clear_counts();
        #1;
        cnt_m6 = 0; cnt_m7 = 0; cnt_rest = 0; cnt_gap = 0; cnt_done = 0; en_rest = 0;
        wrap1 = 0; wrap127 = 0;
    endtask

    task automatic tick_sync();
        int n = 0;
        do begin @(negedge clk); n++; end while (!m_tick && n < 400);
        chk("tick_sync_timeout", m_tick, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        chk(nm, busy, 0);
    endtask

    task automatic load_song();
        rom_mem[0] = ent(0, 1, M6);
        rom_mem[1] = ent(1, 0, M7);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NENT; i++) rom_mem[i] = ent(1, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_addr", bus.rom_addr, 0);
        chk("rst_div", div, 0);
        chk("rst_enable", enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // basic two-note song
        load_song();
        tick_sync(); pulse_start(); clear_counts();
        wait_idle("t1_timeout", 2000);
        @(negedge clk);
        chk("t1_m6_ticks", cnt_m6, 16);
        chk("t1_m7_ticks", cnt_m7, 8);
        chk("t1_done_pulses", cnt_done, 1);
        chk("t1_div_end", div, 0);
        chk("t1_busy_end", busy, 0);
        $display("t1 song: m6=%0d m7=%0d done=%0d", cnt_m6, cnt_m7, cnt_done);

        // looping
        loop = 1'b1;
        tick_sync(); pulse_start(); clear_counts();
        n = 0;
        while (cnt_m6 < 17 && n < 3000) begin @(negedge clk); n++; end
        chk("loop_replay", cnt_m6 >= 17, 1);
        chk("loop_addr_wrap", wrap1, 1);
        chk("loop_no_done", cnt_done, 0);
        $display("loop: m6=%0d wrap=%0d done=%0d", cnt_m6, wrap1, cnt_done);
        pulse_stop(); loop = 1'b0;

        // rest note
        rom_mem[0] = ent(0, 0, 0);
        rom_mem[1] = ent(1, 0, M7);
        tick_sync(); pulse_start(); clear_counts();
        wait_idle("rest_timeout", 2000);
        chk("rest_ticks", cnt_rest, 8);
        chk("rest_enable", en_rest, 0);
        chk("rest_m7_ticks", cnt_m7, 8);
        $display("rest: rest=%0d m7=%0d", cnt_rest, cnt_m7);

        // stop mid-note, then restart
        load_song();
        tick_sync(); pulse_start(); clear_counts();
        n = 0;
        while (cnt_m6 < 3 && n < 1000) begin @(negedge clk); n++; end
        chk("stop_reach3", cnt_m6, 3);
        pulse_stop();
        chk("stop_busy", busy, 0);
        chk("stop_enable", enable, 0);
        chk("stop_div", div, 0);
        repeat (30) @(negedge clk);
        chk("stop_no_done", cnt_done, 0);
        pulse_start();
        chk("restart_addr", bus.rom_addr, 0);
        chk("restart_busy", busy, 1);
        $display("stop: m6=%0d done=%0d", cnt_m6, cnt_done);
        repeat (10) @(negedge clk);
        pulse_stop();

        // start and stop together while idle
        start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("ss_busy_later", busy, 0);
        $display("start+stop idle: busy=%0d", busy);

        // start while playing is ignored
        tick_sync(); pulse_start(); clear_counts();
        n = 0;
        while (!(busy && bus.rom_addr == 1) && n < 1000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        pulse_start();
        chk("busy_start_addr", bus.rom_addr, 1);
        $display("start while busy: addr=%0d", bus.rom_addr);
        pulse_stop();

        // articulation gap between identical notes
        rom_mem[0] = ent(0, 0, M6);
        rom_mem[1] = ent(1, 0, M6);
        tick_sync(); pulse_start(); clear_counts();
        wait_idle("gap_timeout", 2000);
        chk("gap_silent_ticks", cnt_gap, GAP ? 2 : 0);
        chk("gap_total_ticks", cnt_m6, 16);
        $display("gap: silent=%0d ticks=%0d", cnt_gap, cnt_m6);

        // address wrap with no last flag
        for (int i = 0; i < NENT; i++) rom_mem[i] = ent(0, 0, i + 1);
        tempo_half = 3;
        tick_sync(); pulse_start(); clear_counts();
        n = 0;
        while (!wrap127 && n < 20000) begin @(negedge clk); n++; end
        chk("addr_wrap", wrap127, 1);
        $display("wrap: seen=%0d cycles=%0d", wrap127, n);
        pulse_stop();

        // randomised traffic
        for (int i = 0; i < NENT; i++)
            rom_mem[i] = ent(((i % 8) == 7) || ($urandom_range(5, 0) == 0), int'($urandom_range(3, 0)),
                             ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(131071, 1)));
        tempo_rand = 1'b1;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            start = ($urandom_range(40, 0) == 0);
            stop  = ($urandom_range(300, 0) == 0);
            if ($urandom_range(200, 0) == 0) loop = ~loop;
            reset = (cyc == 4000);
            @(negedge clk);
            if (cyc == 4000) begin
                chk("rand_rst_busy", busy, 0);
                chk("rand_rst_enable", enable, 0);
                chk("rand_rst_div", div, 0);
            end
        end
        start = 1'b0; stop = 1'b0; loop = 1'b0; reset = 1'b0;
        repeat (5) @(negedge clk);
        $display("random phase complete: total=%0d", total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
